alu_arbiter: RTL

Two-requester arbiter and sequencer in front of the register-file/ALU core (8×8-bit registers, 7-bit opcode, load/ce command interface, result written to register 0). It accepts commands from two independent requesters over valid/ready handshakes, serialises them onto the core's single command port, and observes the core's load/operation timing. Each requester receives exactly one response pulse per accepted command. It sits between the bus-side command sources and the core.

---
 rtl/alu_arb_pkg.sv | 37 +++
 rtl/rr_arb2.sv | 40 ++++
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// ============================================================================
// Module : alu_arb_pkg
// Brief  : Shared types and field layout for the two-requester ALU arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int OPC_W      = 7;
  localparam int REG_SEL_HI = 6;
  localparam int REG_SEL_LO = 4;
  localparam int ALU_OP_HI  = 3;
  localparam int ALU_OP_LO  = 0;
  localparam int REG_SEL_W  = REG_SEL_HI - REG_SEL_LO + 1;
  localparam int ALU_OP_W   = ALU_OP_HI - ALU_OP_LO + 1;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [REG_SEL_W-1:0] reg_sel;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 cin;
    logic                 cout;
    logic                 load;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way one-hot grant, round-robin or fixed priority to input 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      // On a tie the requester that did not win last time takes the grant.
      always_comb begin
        o_grant = i_req;
        if (&i_req) begin
          o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
      end
    end else begin : g_fixed
      logic w_unused_last;
      assign w_unused_last = i_last_grant;

      always_comb begin
        o_grant = i_req;
        if (i_req[0]) begin
          o_grant = 2'b01;
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Serialises two requesters onto the ALU core command port and
//          returns one response per accepted command.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int OP_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r0_data,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [OPC_W-1:0]  r0_opcode,
  input  logic [OPC_W-1:0]  r1_opcode,
  input  logic              r0_cin,
  input  logic              r1_cin,
  input  logic              r0_cout,
  input  logic              r1_cout,
  input  logic              r0_load,
  input  logic              r1_load,
  output logic              r0_resp_valid,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r0_resp_data,
  output logic [DATA_W-1:0] r1_resp_data,
  output logic [DATA_W-1:0] core_data_in,
  output logic [OPC_W-1:0]  core_opcode,
  output logic              core_cin,
  output logic              core_cout,
  output logic              core_load,
  output logic              core_ce,
  input  logic [DATA_W-1:0] core_data_out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] c_op_lat = CNT_W'(OP_LATENCY);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_owner;
  logic                         r_last_grant;
  logic                         r_ce;
  cmd_t                         r_cmd;
  cmd_t                         w_cmd;
  logic [1:0]                   w_grant;
  logic [1:0]                   w_xfer;
  logic [1:0]                   r_resp_valid;
  logic [1:0][DATA_W-1:0]       r_resp_data;

  rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .i_req        ({r1_valid, r0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is gated by reset so nothing is offered while rst is held low.
  assign w_xfer = w_grant & {2{(r_state == ST_IDLE) && rst}};

  always_comb begin
    w_cmd = '0;
    if (w_grant[1]) begin
      w_cmd.data    = r1_data;
      w_cmd.reg_sel = r1_opcode[REG_SEL_HI:REG_SEL_LO];
      w_cmd.alu_op  = r1_opcode[ALU_OP_HI:ALU_OP_LO];
      w_cmd.cin     = r1_cin;
      w_cmd.cout    = r1_cout;
      w_cmd.load    = r1_load;
    end else begin
      w_cmd.data    = r0_data;
      w_cmd.reg_sel = r0_opcode[REG_SEL_HI:REG_SEL_LO];
      w_cmd.alu_op  = r0_opcode[ALU_OP_HI:ALU_OP_LO];
      w_cmd.cin     = r0_cin;
      w_cmd.cout    = r0_cout;
      w_cmd.load    = r0_load;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (|w_xfer) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = r_cmd.load ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (r_cnt == CNT_W'(1)) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ce         <= 1'b0;
      r_cmd        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_ce         <= 1'b0;
      r_resp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_xfer) begin
            r_cmd        <= w_cmd;
            r_owner      <= w_xfer[1];
            r_last_grant <= w_xfer[1];
            r_ce         <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_cmd.load) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_data[r_owner]  <= r_cmd.data;
          end else begin
            r_cnt <= c_op_lat;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // Last write-back cycle: core register 0 now holds the result.
          if (r_cnt == CNT_W'(1)) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_data[r_owner]  <= core_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign r0_ready      = w_xfer[0];
  assign r1_ready      = w_xfer[1];
  assign r0_resp_valid = r_resp_valid[0];
  assign r1_resp_valid = r_resp_valid[1];
  assign r0_resp_data  = r_resp_data[0];
  assign r1_resp_data  = r_resp_data[1];
  assign core_data_in  = r_cmd.data;
  assign core_opcode   = {r_cmd.reg_sel, r_cmd.alu_op};
  assign core_cin      = r_cmd.cin;
  assign core_cout     = r_cmd.cout;
  assign core_load     = r_cmd.load;
  assign core_ce       = r_ce;
  assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire
